// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and stall-vector stage indices.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } pipe_state_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int N_STG   = 5;

endpackage

// File: rtl/pipe_busy_timer.sv
// Loadable down-counter with hold-at-zero and a zero flag; times the
// EX-hold window of multi-cycle operations.
module pipe_busy_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: memory stall, multi-cycle op hold,
// load-use interlock and branch flush. Optional PIPE_CTRL_PERF_EN adds a
// saturating stall-cycle counter on port perf_stall_cnt.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv_start,
    input  logic             br_taken_ex,
    input  logic             mem_stall_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             flush_id,
    output logic             flush_ex,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
`endif
    output logic             busy
);

    localparam int TW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(DIV_CYCLES - 2);

    if (DIV_CYCLES < 2) begin : g_bad_div
        $error("DIV_CYCLES must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    pipe_state_t        r_state;
    pipe_state_t        w_state_nxt;
    logic               r_br_pend;
    logic               w_start;
    logic               w_zero;
    logic               w_md_hold;
    logic               w_load_use;
    logic               w_flush;
    logic [N_STG-1:0]   w_stall;

    // Start is only accepted when memory is ready; the start cycle itself stalls.
    assign w_start   = (r_state == ST_RUN) && ex_muldiv_start && !mem_stall_req;
    assign w_md_hold = (r_state == ST_MULDIV) || w_start;

    assign w_load_use = (r_state == ST_RUN) && ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_rs1_use && (id_rs1 == ex_rd)) ||
                         (id_rs2_use && (id_rs2 == ex_rd)));

    assign w_flush = !rst && !mem_stall_req && !w_md_hold && (br_taken_ex || r_br_pend);

    always_comb begin
        w_stall = '0;
        if (!rst) begin
            if (mem_stall_req) begin
                w_stall[STG_MEM:STG_IF] = '1;
            end else if (w_md_hold) begin
                w_stall[STG_EX:STG_IF] = '1;
            end else if (w_load_use && !w_flush) begin
                w_stall[STG_ID:STG_IF] = '1;
            end
        end
    end

    assign stall_if  = w_stall[STG_IF];
    assign stall_id  = w_stall[STG_ID];
    assign stall_ex  = w_stall[STG_EX];
    assign stall_mem = w_stall[STG_MEM];
    assign stall_wb  = w_stall[STG_WB];
    assign flush_id  = w_flush;
    assign flush_ex  = w_flush;
    assign busy      = !rst && (r_state == ST_MULDIV);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_start) w_state_nxt = ST_MULDIV;
            ST_MULDIV: if (!mem_stall_req && w_zero) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_br_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (br_taken_ex && mem_stall_req) begin
                r_br_pend <= 1'b1;
            end else if (w_flush) begin
                r_br_pend <= 1'b0;
            end
        end
    end

    pipe_busy_timer #(
        .W(TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start),
        .i_load_val (LOAD_VAL),
        .i_en       ((r_state == ST_MULDIV) && !mem_stall_req),
        .o_zero     (w_zero)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (stall_if && !(&r_perf)) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_stall_cnt = r_perf;
`endif

endmodule
